// File: rtl/operand_fetch.sv
// Operand-fetch stage: decodes the fetched word, reads the 16x32 register file and
// registers operands, immediate and branch target. Define OF_BYPASS_EN for write-to-read forwarding.
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] of_pc,
  output logic [31:0] of_inst,
  output logic        of_valid,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [31:0] imm,
  output logic [31:0] branchTarget,
  output logic [3:0]  rd
);

  localparam logic [31:0] NopInst  = 32'h6800_0000;
  localparam logic [4:0]  OpRet    = 5'b10100;
  localparam logic [4:0]  OpStore  = 5'b01111;
  localparam logic [3:0]  RetAddrReg = 4'd15;

  logic [31:0] regs_q [16];

  logic [31:0] of_pc_q, of_pc_d;
  logic [31:0] of_inst_q, of_inst_d;
  logic        of_valid_q, of_valid_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] branchTarget_q, branchTarget_d;
  logic [3:0]  rd_q, rd_d;

  logic [4:0]  opcode;
  logic [3:0]  rdField, rs1Field, rs2Field;
  logic [3:0]  rdAddr1, rdAddr2;
  logic [31:0] rdData1, rdData2;
  logic [31:0] immDec;
  logic [31:0] branchOffset;

  assign opcode   = instruction[31:27];
  assign rdField  = instruction[25:22];
  assign rs1Field = instruction[21:18];
  assign rs2Field = instruction[17:14];

  // ret reads the return-address register; store reads its data register through rd
  assign rdAddr1 = (opcode == OpRet)   ? RetAddrReg : rs1Field;
  assign rdAddr2 = (opcode == OpStore) ? rdField    : rs2Field;

`ifdef OF_BYPASS_EN
  assign rdData1 = (wb_en && (wb_addr == rdAddr1)) ? wb_data : regs_q[rdAddr1];
  assign rdData2 = (wb_en && (wb_addr == rdAddr2)) ? wb_data : regs_q[rdAddr2];
`else
  assign rdData1 = regs_q[rdAddr1];
  assign rdData2 = regs_q[rdAddr2];
`endif

  always_comb begin
    immDec = {{16{instruction[15]}}, instruction[15:0]};
    case (instruction[17:16])
      2'b01:   immDec = {16'h0000, instruction[15:0]};
      2'b10:   immDec = {instruction[15:0], 16'h0000};
      default: immDec = {{16{instruction[15]}}, instruction[15:0]};
    endcase
  end

  assign branchOffset = {{5{instruction[26]}}, instruction[26:0]} << 2;

  // flush beats stall; a stall alone keeps every captured field
  always_comb begin
    of_pc_d        = of_pc_q;
    of_inst_d      = of_inst_q;
    of_valid_d     = of_valid_q;
    op1_d          = op1_q;
    op2_d          = op2_q;
    imm_d          = imm_q;
    branchTarget_d = branchTarget_q;
    rd_d           = rd_q;
    if (flush) begin
      of_pc_d        = pc;
      of_inst_d      = NopInst;
      of_valid_d     = 1'b0;
      op1_d          = '0;
      op2_d          = '0;
      imm_d          = '0;
      branchTarget_d = '0;
      rd_d           = '0;
    end else if (!stall) begin
      of_pc_d        = pc;
      of_inst_d      = instruction;
      of_valid_d     = 1'b1;
      op1_d          = rdData1;
      op2_d          = rdData2;
      imm_d          = immDec;
      branchTarget_d = pc + branchOffset;
      rd_d           = rdField;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      of_pc_q        <= '0;
      of_inst_q      <= NopInst;
      of_valid_q     <= 1'b0;
      op1_q          <= '0;
      op2_q          <= '0;
      imm_q          <= '0;
      branchTarget_q <= '0;
      rd_q           <= '0;
    end else begin
      of_pc_q        <= of_pc_d;
      of_inst_q      <= of_inst_d;
      of_valid_q     <= of_valid_d;
      op1_q          <= op1_d;
      op2_q          <= op2_d;
      imm_q          <= imm_d;
      branchTarget_q <= branchTarget_d;
      rd_q           <= rd_d;
    end
  end

  // write-back is independent of stall and flush; r0 is an ordinary register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign of_pc        = of_pc_q;
  assign of_inst      = of_inst_q;
  assign of_valid     = of_valid_q;
  assign op1          = op1_q;
  assign op2          = op2_q;
  assign imm          = imm_q;
  assign branchTarget = branchTarget_q;
  assign rd           = rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios followed by random traffic,
// compared against an arithmetic reference model of the stage and register file.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcIn, instIn;
  logic        stallIn, flushIn, wbEn;
  logic [3:0]  wbAddr;
  logic [31:0] wbData;
  logic [31:0] ofPc, ofInst, op1, op2, imm, branchTarget;
  logic        ofValid;
  logic [3:0]  rd;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [31:0] modelRf [16];
  logic [31:0] ePc, eInst, eOp1, eOp2, eImm, eBt;
  logic        eValid;
  logic [3:0]  eRd;

  operand_fetch dut (
    .clk(clk), .rst(rst), .pc(pcIn), .instruction(instIn),
    .stall(stallIn), .flush(flushIn),
    .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData),
    .of_pc(ofPc), .of_inst(ofInst), .of_valid(ofValid),
    .op1(op1), .op2(op2), .imm(imm), .branchTarget(branchTarget), .rd(rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modelImm(input logic [31:0] inst);
    int v;
    v = int'(inst[15:0]);
    case (inst[17:16])
      2'b01: return 32'(v);
      2'b10: return 32'(v * 65536);
      default: begin
        if (v >= 32768) v = v - 65536;
        return 32'(v);
      end
    endcase
  endfunction

  function automatic logic [31:0] modelBranch(input logic [31:0] p, input logic [31:0] inst);
    longint off;
    off = longint'(inst[26:0]);
    if (off >= 67108864) off = off - 134217728;
    return 32'(longint'(p) + off * 4);
  endfunction

  function automatic logic [31:0] modelRead(input int addr, input logic we,
                                            input logic [3:0] wa, input logic [31:0] wd);
`ifdef OF_BYPASS_EN
    if (we && int'(wa) == addr) return wd;
`endif
    return modelRf[addr];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) modelRf[i] = '0;
    ePc = '0; eInst = 32'h6800_0000; eValid = 1'b0;
    eOp1 = '0; eOp2 = '0; eImm = '0; eBt = '0; eRd = '0;
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".of_pc"}, ofPc, ePc);
    checkOne({tag, ".of_inst"}, ofInst, eInst);
    checkOne({tag, ".of_valid"}, 32'(ofValid), 32'(eValid));
    checkOne({tag, ".op1"}, op1, eOp1);
    checkOne({tag, ".op2"}, op2, eOp2);
    checkOne({tag, ".imm"}, imm, eImm);
    checkOne({tag, ".branchTarget"}, branchTarget, eBt);
    checkOne({tag, ".rd"}, 32'(rd), 32'(eRd));
  endtask

  // drives one cycle, predicts the captured values from the pre-edge state, then checks
  task automatic applyStimulus(input logic [31:0] p, input logic [31:0] inst,
                               input logic st, input logic fl,
                               input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input string tag);
    int a1, a2;
    pcIn = p; instIn = inst; stallIn = st; flushIn = fl;
    wbEn = we; wbAddr = wa; wbData = wd;
    a1 = (inst[31:27] == 5'b10100) ? 15 : int'(inst[21:18]);
    a2 = (inst[31:27] == 5'b01111) ? int'(inst[25:22]) : int'(inst[17:14]);
    if (fl) begin
      ePc = p; eInst = 32'h6800_0000; eValid = 1'b0;
      eOp1 = '0; eOp2 = '0; eImm = '0; eBt = '0; eRd = '0;
    end else if (!st) begin
      ePc = p; eInst = inst; eValid = 1'b1;
      eOp1 = modelRead(a1, we, wa, wd);
      eOp2 = modelRead(a2, we, wa, wd);
      eImm = modelImm(inst);
      eBt  = modelBranch(p, inst);
      eRd  = inst[25:22];
    end
    @(posedge clk);
    #1;
    if (we) modelRf[wa] = wd;
    wbEn = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    logic [31:0] rInst;
    rst = 1'b1; pcIn = '0; instIn = '0; stallIn = 1'b0; flushIn = 1'b0;
    wbEn = 1'b0; wbAddr = '0; wbData = '0;
    modelReset();
    #2;
    checkOutput("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // operand read of add r3,r1,r2
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd5, "wr_r1");
    applyStimulus(32'h4, 32'h0, 1'b0, 1'b0, 1'b1, 4'd2, 32'd2, "wr_r2");
    applyStimulus(32'h8, 32'h00C4_8000, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "add");

    // branch targets including negative wrap
    applyStimulus(32'h20, 32'h8800_0010, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "bgt");
    applyStimulus(32'h0, 32'h8FFF_FFFF, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "bneg");

    // immediate modifiers
    applyStimulus(32'h30, 32'h4C40_FFFF, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "imm_sx");
    applyStimulus(32'h34, 32'h4C41_FFFF, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "imm_zx");
    applyStimulus(32'h38, 32'h4C42_ABCD, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "imm_hi");
    applyStimulus(32'h3C, 32'h4C43_8001, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "imm_m3");

    // ret reads r15, st reads rd as second operand
    applyStimulus(32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 4'd15, 32'hCAFE_0040, "wr_r15");
    applyStimulus(32'h44, 32'hA000_0000, 1'b0, 1'b0, 1'b1, 4'd7, 32'h7777_0000, "ret");
    applyStimulus(32'h48, 32'h79C4_8000, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "store");

    // stall holds while inputs change, stall+flush loads a bubble
    applyStimulus(32'h50, 32'h00C4_8000, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "stall1");
    applyStimulus(32'h54, 32'h4C42_1234, 1'b1, 1'b0, 1'b1, 4'd2, 32'd11, "stall2");
    applyStimulus(32'h58, 32'h00C4_8000, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0, "stallflush");

    // same-cycle write and read of r1
    applyStimulus(32'h5C, 32'h00C4_8000, 1'b0, 1'b0, 1'b1, 4'd1, 32'd9, "rawsame");
    applyStimulus(32'h60, 32'h00C4_8000, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "rawnext");

    // r0 is writable
    applyStimulus(32'h64, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h1234_5678, "wr_r0");
    applyStimulus(32'h68, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "rd_r0");

    // async reset mid-run, with writes/stall/flush ignored while held
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_async");
    wbEn = 1'b1; wbAddr = 4'd1; wbData = 32'hDEAD_BEEF; flushIn = 1'b1; stallIn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_held");
    wbEn = 1'b0; flushIn = 1'b0; stallIn = 1'b0;
    rst = 1'b0;
    applyStimulus(32'h70, 32'h00C4_8000, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "post_rst_a");
    applyStimulus(32'h74, 32'h79C4_8000, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "post_rst_b");
    applyStimulus(32'h78, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "post_rst_c");

    // random traffic
    for (int n = 0; n < 300; n++) begin
      rInst = $urandom;
      case ($urandom_range(0, 3))
        0: rInst[31:27] = 5'b10100;
        1: rInst[31:27] = 5'b01111;
        default: ;
      endcase
      applyStimulus($urandom, rInst,
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 1) == 1), 4'($urandom), $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
